// File: rtl/rotor3_return_if.sv
// Handshake bundle for the rotor-3 return stage: reflector-side input,
// rotor-2-side output.
interface rotor3_return_if;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_code;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_code;
  logic       out_err;

  modport master (
    output in_valid, in_code, out_ready,
    input  in_ready, out_valid, out_code, out_err
  );

  modport slave (
    input  in_valid, in_code, out_ready,
    output in_ready, out_valid, out_code, out_err
  );
endinterface

// File: rtl/rotor3_return.sv
// Rotor-3 return path: inverse wiring substitution with its own position
// register (load/step/notch carry) and a two-stage valid/ready pipeline.
module rotor3_return #(
  parameter int unsigned NOTCH     = 21,
  parameter int unsigned RESET_POS = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [4:0]       load_pos,
  input  logic             step,
  output logic [4:0]       pos,
  output logic             carry,
  rotor3_return_if.slave   bus
);

  localparam logic [4:0] L_NOTCH = 5'(NOTCH);
  localparam logic [4:0] L_RST   = 5'(RESET_POS);

  logic [4:0] r_pos;
  logic       r_carry;

  logic       r_s1_valid;
  logic [4:0] r_s1_t;
  logic       r_s1_err;

  logic       r_s2_valid;
  logic [4:0] r_out_code;
  logic       r_out_err;

  logic       w_s2_load;
  logic       w_s1_adv;
  logic       w_in_ready;
  logic       w_accept;
  logic [5:0] w_sum;
  logic [5:0] w_mod;
  logic [4:0] w_t;
  logic       w_err;
  logic [4:0] w_lut;

  assign pos           = r_pos;
  assign carry         = r_carry;
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_s2_valid;
  assign bus.out_code  = r_out_code;
  assign bus.out_err   = r_out_err;

  // Pipeline flow control: stage 2 refills when empty or drained this cycle.
  always_comb begin
    w_s2_load  = !r_s2_valid || bus.out_ready;
    w_s1_adv   = r_s1_valid && w_s2_load;
    w_in_ready = !r_s1_valid || w_s2_load;
    w_accept   = bus.in_valid && w_in_ready;
  end

  // Offset removal: (in_code + 26 - pos) mod 26, zero folded onto 26.
  // Sum never exceeds 57, so two conditional subtractions cover the modulus.
  always_comb begin
    w_sum = {1'b0, bus.in_code} + 6'd26 - {1'b0, r_pos};
    if (w_sum >= 6'd52)
      w_mod = w_sum - 6'd52;
    else if (w_sum >= 6'd26)
      w_mod = w_sum - 6'd26;
    else
      w_mod = w_sum;
    w_t   = (w_mod == 6'd0) ? 5'd26 : w_mod[4:0];
    w_err = (bus.in_code > 5'd25);
  end

  // Inverse rotor-3 wiring, indexed by the offset-corrected contact 1..26.
  always_comb begin
    w_lut = '0;
    case (r_s1_t)
      5'd1:  w_lut = 5'd12;
      5'd2:  w_lut = 5'd15;
      5'd3:  w_lut = 5'd18;
      5'd4:  w_lut = 5'd19;
      5'd5:  w_lut = 5'd17;
      5'd6:  w_lut = 5'd8;
      5'd7:  w_lut = 5'd24;
      5'd8:  w_lut = 5'd2;
      5'd9:  w_lut = 5'd20;
      5'd10: w_lut = 5'd13;
      5'd11: w_lut = 5'd23;
      5'd12: w_lut = 5'd22;
      5'd13: w_lut = 5'd4;
      5'd14: w_lut = 5'd1;
      5'd15: w_lut = 5'd26;
      5'd16: w_lut = 5'd5;
      5'd17: w_lut = 5'd14;
      5'd18: w_lut = 5'd6;
      5'd19: w_lut = 5'd9;
      5'd20: w_lut = 5'd7;
      5'd21: w_lut = 5'd25;
      5'd22: w_lut = 5'd10;
      5'd23: w_lut = 5'd16;
      5'd24: w_lut = 5'd3;
      5'd25: w_lut = 5'd11;
      5'd26: w_lut = 5'd21;
      default: w_lut = '0;
    endcase
  end

  // Rotor position: legal load wins over step; an illegal load also blocks step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos   <= L_RST;
      r_carry <= 1'b0;
    end else begin
      r_carry <= 1'b0;
      if (load) begin
        if (load_pos <= 5'd25)
          r_pos <= load_pos;
      end else if (step) begin
        r_pos   <= (r_pos == 5'd25) ? 5'd0 : r_pos + 5'd1;
        r_carry <= (r_pos == L_NOTCH);
      end
    end
  end

  // Stage 1: capture offset-corrected contact and error flag on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_t     <= '0;
      r_s1_err   <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_t     <= w_t;
      r_s1_err   <= w_err;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Stage 2: registered lookup result; held while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_out_code <= '0;
      r_out_err  <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_code <= r_s1_err ? 5'd0 : w_lut;
        r_out_err  <= r_s1_err;
      end
    end
  end

endmodule

// File: tb/tb_rotor3_return.sv
// Self-checking bench for rotor3_return: vector table, forward-model sweep,
// position/carry, stall and reset sequences, with an output scoreboard.
module tb_rotor3_return;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [4:0] load_pos;
  logic       step;
  logic [4:0] pos;
  logic       carry;

  rotor3_return_if bus ();

  rotor3_return #(.NOTCH(21), .RESET_POS(0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_pos (load_pos),
    .step     (step),
    .pos      (pos),
    .carry    (carry),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [4:0] e_code;
  logic       e_err;
  logic [5:0] sb[$];

  typedef struct {
    logic [4:0] p;
    logic [4:0] code;
    logic [4:0] exp_code;
    logic       exp_err;
  } vec_t;

  vec_t vecs[8];

  // Forward rotor-3 wiring x=1..26 -> contact.
  int fwd[1:26] = '{14, 8, 24, 13, 16, 18, 20, 6, 19, 22, 25, 1, 10,
                    17, 2, 23, 5, 3, 4, 9, 26, 12, 11, 7, 21, 15};

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard: push expectation on acceptance, pop/compare on output transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output got=%0d err=%0d", bus.out_code, bus.out_err);
        end else begin
          check("out_code_err", int'({bus.out_err, bus.out_code}), int'(sb.pop_front()));
        end
      end
      if (bus.in_valid && bus.in_ready)
        sb.push_back({e_err, e_code});
    end
  end

  task automatic set_pos(input logic [4:0] p);
    load = 1'b1;
    load_pos = p;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic send(input logic [4:0] c, input logic [4:0] ec, input logic ee);
    bus.in_valid = 1'b1;
    bus.in_code  = c;
    e_code = ec;
    e_err  = ee;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        return;
      end
    end
    n_cmp++;
    n_bad++;
    $display("FAIL send_timeout got=in_ready_low expected=accept");
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100; k++) begin
      if (sb.size() == 0) return;
      @(posedge clk); #1;
    end
    check("drain_remaining", sb.size(), 0);
  endtask

  initial begin
    int c0;
    rst_n = 1'b0;
    load = 1'b0;
    load_pos = '0;
    step = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_code = '0;
    bus.out_ready = 1'b1;
    e_code = '0;
    e_err = 1'b0;

    vecs[0] = '{p: 5'd0,  code: 5'd13, exp_code: 5'd4,  exp_err: 1'b0};
    vecs[1] = '{p: 5'd0,  code: 5'd0,  exp_code: 5'd21, exp_err: 1'b0};
    vecs[2] = '{p: 5'd5,  code: 5'd19, exp_code: 5'd1,  exp_err: 1'b0};
    vecs[3] = '{p: 5'd25, code: 5'd3,  exp_code: 5'd19, exp_err: 1'b0};
    vecs[4] = '{p: 5'd25, code: 5'd25, exp_code: 5'd21, exp_err: 1'b0};
    vecs[5] = '{p: 5'd1,  code: 5'd0,  exp_code: 5'd11, exp_err: 1'b0};
    vecs[6] = '{p: 5'd0,  code: 5'd27, exp_code: 5'd0,  exp_err: 1'b1};
    vecs[7] = '{p: 5'd12, code: 5'd31, exp_code: 5'd0,  exp_err: 1'b1};

    #22 rst_n = 1'b1;

    // Reset state
    check("rst_pos", pos, 0);
    check("rst_carry", carry, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_code", bus.out_code, 0);
    check("rst_out_err", bus.out_err, 0);
    check("rst_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;

    // Latency: accepted letter shows up two cycles later
    send(5'd13, 5'd4, 1'b0);
    check("lat_cycle1_valid", bus.out_valid, 0);
    @(posedge clk); #1;
    check("lat_cycle2_valid", bus.out_valid, 1);
    check("lat_cycle2_code", bus.out_code, 4);
    drain();

    // Vector table
    for (int i = 0; i < 8; i++) begin
      set_pos(vecs[i].p);
      send(vecs[i].code, vecs[i].exp_code, vecs[i].exp_err);
    end
    drain();

    // Forward-model sweep with sustained throughput check
    for (int r = 0; r < 26; r++) begin
      set_pos(5'(r));
      c0 = cyc;
      for (int x = 1; x <= 26; x++)
        send(5'((fwd[x] + r) % 26), 5'(x), 1'b0);
      check("sweep_cycles", cyc - c0, 26);
    end
    drain();

    // Position register and carry
    set_pos(5'd20);
    step = 1'b1; @(posedge clk); #1; step = 1'b0;
    check("step20_pos", pos, 21);
    check("step20_carry", carry, 0);
    step = 1'b1; @(posedge clk); #1; step = 1'b0;
    check("notch_pos", pos, 22);
    check("notch_carry", carry, 1);
    @(posedge clk); #1;
    check("notch_carry_pulse", carry, 0);
    set_pos(5'd25);
    step = 1'b1; @(posedge clk); #1; step = 1'b0;
    check("wrap_pos", pos, 0);
    check("wrap_carry", carry, 0);
    set_pos(5'd21);
    load = 1'b1; load_pos = 5'd7; step = 1'b1;
    @(posedge clk); #1;
    check("load_step_pos", pos, 7);
    check("load_step_carry", carry, 0);
    load_pos = 5'd30;
    @(posedge clk); #1;
    load = 1'b0; step = 1'b0;
    check("bad_load_pos", pos, 7);
    check("bad_load_carry", carry, 0);

    // Stall: two letters fill the pipe, third waits, output held
    set_pos(5'd0);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_code = 5'd13; e_code = 5'd4; e_err = 1'b0;
    @(posedge clk); #1;
    bus.in_code = 5'd19; e_code = 5'd9;
    @(posedge clk); #1;
    bus.in_code = 5'd0; e_code = 5'd21;
    check("stall_in_ready", bus.in_ready, 0);
    check("stall_out_valid", bus.out_valid, 1);
    check("stall_code_a", bus.out_code, 4);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("stall_in_ready_held", bus.in_ready, 0);
    check("stall_code_held", bus.out_code, 4);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    drain();
    check("stall_sb_empty", sb.size(), 0);

    // Reset mid-stream with a letter on the output
    set_pos(5'd9);
    bus.out_ready = 1'b0;
    send(5'd13, 5'd19, 1'b0);
    @(posedge clk); #1;
    check("pre_rst_out_valid", bus.out_valid, 1);
    check("pre_rst_out_code", bus.out_code, 19);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", bus.out_valid, 0);
    check("async_rst_out_code", bus.out_code, 0);
    check("async_rst_pos", pos, 0);
    check("async_rst_in_ready", bus.in_ready, 1);
    sb.delete();
    #3 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("post_rst_out_valid", bus.out_valid, 0);
    check("post_rst_sb", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
